// File: rtl/shift_receiver.sv
// rtl/shift_receiver.sv - serial frame receiver: FR starts a frame, SV strobes SI in MSB first
// Optional even-parity bit after the data word: define SHIFT_RECEIVER_PARITY_EN.
module shift_receiver #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         FR,
  input  logic         SV,
  input  logic         SI,
  output logic [N-1:0] Q,
  output logic         D,
  output logic         BUSY,
  output logic         ERR,
  output logic         PE
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    PAR  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t         STATE;
  logic [N-1:0]   sr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   nxt_word;

  // Word as it would look after shifting in the current SI
  assign nxt_word = {sr[N-2:0], SI};

  // Done and busy decode directly from the state register (Moore outputs)
  assign D    = (STATE == DONE);
  assign BUSY = (STATE == RECV) || (STATE == PAR);

`ifdef SHIFT_RECEIVER_PARITY_EN
  logic pe_q;
  assign PE = pe_q;
`else
  assign PE = 1'b0;
`endif

  // Frame FSM, shift register, bit counter, word/error/parity registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STATE <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      Q     <= '0;
      ERR   <= 1'b0;
`ifdef SHIFT_RECEIVER_PARITY_EN
      pe_q  <= 1'b0;
`endif
    end else begin
      ERR <= 1'b0;
      case (STATE)
        IDLE: begin
          if (FR) begin
            sr    <= '0;
            cnt   <= '0;
            STATE <= RECV;
          end
        end
        RECV: begin
          if (FR) begin
            // Frame restarted before completion: flag it and start over
            ERR <= 1'b1;
            sr  <= '0;
            cnt <= '0;
          end else if (SV) begin
            sr <= nxt_word;
            if (cnt == CW'(N - 1)) begin
              Q   <= nxt_word;
              cnt <= '0;
`ifdef SHIFT_RECEIVER_PARITY_EN
              STATE <= PAR;
`else
              STATE <= DONE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PAR: begin
`ifdef SHIFT_RECEIVER_PARITY_EN
          if (FR) begin
            ERR   <= 1'b1;
            sr    <= '0;
            cnt   <= '0;
            STATE <= RECV;
          end else if (SV) begin
            // Q already holds the new word; even parity means ^Q ^ SI == 0
            pe_q  <= (^Q) ^ SI;
            STATE <= DONE;
          end
`else
          STATE <= IDLE;
`endif
        end
        DONE: begin
          if (FR) begin
            sr    <= '0;
            cnt   <= '0;
            STATE <= RECV;
          end else begin
            STATE <= IDLE;
          end
        end
        default: STATE <= IDLE;
      endcase
    end
  end

endmodule
